// File: rtl/csr_access_controller.sv
// Sequences CSR read-modify-write accesses over the shared CSR bus and arbitrates core vs. management.
// Optional management port is enabled by defining CSR_MGMT_PORT_EN.
module csr_access_controller #(
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coreValid,
  input  logic [1:0]               coreOp,
  input  logic [ADDRESS_WIDTH-1:0] coreAddress,
  input  logic [31:0]              coreWriteData,
  output logic                     coreReady,
  output logic [31:0]              coreReadData,
  output logic                     coreError,
  input  logic                     mgmtValid,
  input  logic                     mgmtWrite,
  input  logic [ADDRESS_WIDTH-1:0] mgmtAddress,
  input  logic [31:0]              mgmtWriteData,
  output logic                     mgmtReady,
  output logic [31:0]              mgmtReadData,
  output logic                     mgmtError,
  output logic                     csrReadEnable,
  output logic                     csrWriteEnable,
  output logic [ADDRESS_WIDTH-1:0] csrAddress,
  output logic [31:0]              csrWriteData,
  input  logic [31:0]              csrReadData,
  input  logic                     csrRequestOutput
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, sel_addr, csr_addr_d, csr_addr_q;
  logic [1:0]               op_q, sel_op;
  logic [31:0]              wdata_q, sel_wdata, old_q;
  logic                     claimed_q, mgmt_q;
  logic                     grant_core, grant_mgmt, grant_any;
  logic                     re_d, re_q, we_d, we_q;
  logic [31:0]              wd_d, wd_q, rdata_done;
  logic                     err_done, read_only, done_core;
  logic                     core_rdy_q, core_err_q;
  logic [31:0]              core_rdata_q;

  function automatic logic need_write_f(input logic [1:0] op, input logic [31:0] wd);
    return (op == 2'b01) || (op[1] && (wd != 32'd0));
  endfunction

  function automatic logic [31:0] new_value_f(input logic [1:0] op, input logic [31:0] old,
                                               input logic [31:0] wd);
    case (op)
      2'b10:   return old | wd;
      2'b11:   return old & ~wd;
      default: return wd;
    endcase
  endfunction

`ifdef CSR_MGMT_PORT_EN
  logic last_mgmt_q;
  logic done_mgmt, mgmt_rdy_q, mgmt_err_q;
  logic [31:0] mgmt_rdata_q;

  // Round-robin on a tie: the requester not served last wins.
  always_comb begin
    grant_mgmt = mgmtValid && (!coreValid || !last_mgmt_q);
    grant_core = coreValid && !grant_mgmt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_mgmt_q  <= 1'b1;
      mgmt_rdy_q   <= 1'b0;
      mgmt_err_q   <= 1'b0;
      mgmt_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && grant_any) last_mgmt_q <= grant_mgmt;
      mgmt_rdy_q   <= done_mgmt;
      mgmt_err_q   <= done_mgmt && err_done;
      mgmt_rdata_q <= done_mgmt ? rdata_done : '0;
    end
  end

  assign done_mgmt    = (state_q == WRITE) && mgmt_q;
  assign mgmtReady    = mgmt_rdy_q;
  assign mgmtError    = mgmt_err_q;
  assign mgmtReadData = mgmt_rdata_q;
`else
  logic unused_mgmt;

  always_comb begin
    grant_core = coreValid;
    grant_mgmt = 1'b0;
  end

  assign unused_mgmt  = ^{mgmtValid, mgmtWrite, mgmtAddress, mgmtWriteData};
  assign mgmtReady    = 1'b0;
  assign mgmtError    = 1'b0;
  assign mgmtReadData = '0;
`endif

  assign grant_any = grant_core || grant_mgmt;
  assign sel_addr  = grant_mgmt ? mgmtAddress : coreAddress;
  assign sel_op    = grant_mgmt ? {1'b0, mgmtWrite} : coreOp;
  assign sel_wdata = grant_mgmt ? mgmtWriteData : coreWriteData;
  assign read_only = (addr_q[ADDRESS_WIDTH-1 -: 2] == 2'b11);
  assign done_core = (state_q == WRITE) && !mgmt_q;

  always_comb begin
    state_d    = state_q;
    re_d       = 1'b0;
    we_d       = 1'b0;
    csr_addr_d = '0;
    wd_d       = '0;
    rdata_done = claimed_q ? old_q : '0;
    err_done   = !claimed_q || (need_write_f(op_q, wdata_q) && read_only);
    unique case (state_q)
      IDLE: if (grant_any) begin
        state_d    = READ;
        re_d       = 1'b1;
        csr_addr_d = sel_addr;
      end
      READ: begin
        // Write decision uses the live bus read so the write lands in the very next cycle.
        state_d    = WRITE;
        csr_addr_d = addr_q;
        we_d       = need_write_f(op_q, wdata_q) && csrRequestOutput && !read_only;
        if (we_d) wd_d = new_value_f(op_q, csrReadData, wdata_q);
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      csr_addr_q   <= '0;
      wd_q         <= '0;
      core_rdy_q   <= 1'b0;
      core_err_q   <= 1'b0;
      core_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      re_q         <= re_d;
      we_q         <= we_d;
      csr_addr_q   <= csr_addr_d;
      wd_q         <= wd_d;
      core_rdy_q   <= done_core;
      core_err_q   <= done_core && err_done;
      core_rdata_q <= done_core ? rdata_done : '0;
    end
  end

  // Request fields and read results; only consumed in states entered after they are written.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && grant_any) begin
      addr_q  <= sel_addr;
      op_q    <= sel_op;
      wdata_q <= sel_wdata;
      mgmt_q  <= grant_mgmt;
    end
    if (state_q == READ) begin
      old_q     <= csrReadData;
      claimed_q <= csrRequestOutput;
    end
  end

  assign csrReadEnable  = re_q;
  assign csrWriteEnable = we_q;
  assign csrAddress     = csr_addr_q;
  assign csrWriteData   = wd_q;
  assign coreReady      = core_rdy_q;
  assign coreError      = core_err_q;
  assign coreReadData   = core_rdata_q;

endmodule

// File: tb/tb_csr_access_controller.sv
// Directed self-checking bench for csr_access_controller with a simple one-register bus responder.
module tb_csr_access_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coreValid = 1'b0;
  logic [1:0]  coreOp = 2'b00;
  logic [11:0] coreAddress = '0;
  logic [31:0] coreWriteData = '0;
  logic        coreReady, coreError;
  logic [31:0] coreReadData;
  logic        mgmtValid = 1'b0;
  logic        mgmtWrite = 1'b0;
  logic [11:0] mgmtAddress = '0;
  logic [31:0] mgmtWriteData = '0;
  logic        mgmtReady, mgmtError;
  logic [31:0] mgmtReadData;
  logic        csrReadEnable, csrWriteEnable;
  logic [11:0] csrAddress;
  logic [31:0] csrWriteData;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;

  logic [31:0] rd_val = '0;
  logic        claim_val = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  assign csrReadData      = csrReadEnable ? rd_val : 32'd0;
  assign csrRequestOutput = csrReadEnable & claim_val;

  always #5 clk = ~clk;

  csr_access_controller #(.ADDRESS_WIDTH(12)) dut (
    .clk(clk), .rst(rst),
    .coreValid(coreValid), .coreOp(coreOp), .coreAddress(coreAddress),
    .coreWriteData(coreWriteData), .coreReady(coreReady), .coreReadData(coreReadData),
    .coreError(coreError),
    .mgmtValid(mgmtValid), .mgmtWrite(mgmtWrite), .mgmtAddress(mgmtAddress),
    .mgmtWriteData(mgmtWriteData), .mgmtReady(mgmtReady), .mgmtReadData(mgmtReadData),
    .mgmtError(mgmtError),
    .csrReadEnable(csrReadEnable), .csrWriteEnable(csrWriteEnable), .csrAddress(csrAddress),
    .csrWriteData(csrWriteData), .csrReadData(csrReadData), .csrRequestOutput(csrRequestOutput)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic core_access(input string name, input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] wd, input logic [31:0] old, input logic claim,
                             input logic exp_we, input logic [31:0] exp_wd,
                             input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    rd_val = old; claim_val = claim;
    coreValid = 1'b1; coreOp = op; coreAddress = addr; coreWriteData = wd;
    @(posedge clk); #1;
    check_eq({name, " read_en"}, {31'd0, csrReadEnable}, 32'd1);
    check_eq({name, " read_addr"}, {20'd0, csrAddress}, {20'd0, addr});
    @(posedge clk); #1;
    check_eq({name, " write_en"}, {31'd0, csrWriteEnable}, {31'd0, exp_we});
    check_eq({name, " write_data"}, csrWriteData, exp_wd);
    check_eq({name, " write_addr"}, {20'd0, csrAddress}, {20'd0, addr});
    check_eq({name, " early_ready"}, {31'd0, coreReady}, 32'd0);
    @(posedge clk); #1;
    check_eq({name, " ready"}, {31'd0, coreReady}, 32'd1);
    check_eq({name, " rdata"}, coreReadData, exp_rd);
    check_eq({name, " error"}, {31'd0, coreError}, {31'd0, exp_err});
    check_eq({name, " mgmt_ready"}, {31'd0, mgmtReady}, 32'd0);
    check_eq({name, " done_wen"}, {31'd0, csrWriteEnable}, 32'd0);
    coreValid = 1'b0;
    @(posedge clk); #1;
    check_eq({name, " ready_drop"}, {31'd0, coreReady}, 32'd0);
    check_eq({name, " idle_addr"}, {20'd0, csrAddress}, 32'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst read_en", {31'd0, csrReadEnable}, 32'd0);
    check_eq("rst write_en", {31'd0, csrWriteEnable}, 32'd0);
    check_eq("rst addr", {20'd0, csrAddress}, 32'd0);
    check_eq("rst wdata", csrWriteData, 32'd0);
    check_eq("rst core_ready", {31'd0, coreReady}, 32'd0);
    check_eq("rst core_rdata", coreReadData, 32'd0);
    check_eq("rst mgmt_ready", {31'd0, mgmtReady}, 32'd0);
    @(negedge clk); rst = 1'b1;

    core_access("rw340", 2'b01, 12'h340, 32'hDEADBEEF, 32'h1234, 1'b1, 1'b1, 32'hDEADBEEF, 32'h1234, 1'b0);
    core_access("rs300", 2'b10, 12'h300, 32'h80, 32'h08, 1'b1, 1'b1, 32'h88, 32'h08, 1'b0);
    core_access("rc300", 2'b11, 12'h300, 32'h08, 32'h88, 1'b1, 1'b1, 32'h80, 32'h88, 1'b0);
    core_access("rs0", 2'b10, 12'h300, 32'h0, 32'h80, 1'b1, 1'b0, 32'h0, 32'h80, 1'b0);
    core_access("unclaimed", 2'b01, 12'h7C0, 32'h1, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    core_access("ro_write", 2'b01, 12'hC00, 32'h1, 32'hABCD, 1'b1, 1'b0, 32'h0, 32'hABCD, 1'b1);
    core_access("ro_read", 2'b00, 12'hC00, 32'h5, 32'h77, 1'b1, 1'b0, 32'h0, 32'h77, 1'b0);
    core_access("rc305", 2'b11, 12'h305, 32'hFF, 32'hF0F0, 1'b1, 1'b1, 32'hF000, 32'hF0F0, 1'b0);

    // Reset in the middle of a write cycle.
    @(negedge clk);
    rd_val = 32'h1; claim_val = 1'b1;
    coreValid = 1'b1; coreOp = 2'b01; coreAddress = 12'h340; coreWriteData = 32'hCAFE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("abort pre_wen", {31'd0, csrWriteEnable}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("abort wen", {31'd0, csrWriteEnable}, 32'd0);
    check_eq("abort addr", {20'd0, csrAddress}, 32'd0);
    check_eq("abort wdata", csrWriteData, 32'd0);
    coreValid = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("abort idle_ren", {31'd0, csrReadEnable | csrWriteEnable}, 32'd0);
      check_eq("abort no_ready", {31'd0, coreReady}, 32'd0);
    end

`ifdef CSR_MGMT_PORT_EN
    // Both requesters held: core, mgmt, core, mgmt with ready every 4 cycles.
    @(negedge clk);
    rd_val = 32'h42; claim_val = 1'b1;
    coreValid = 1'b1; coreOp = 2'b00; coreAddress = 12'h200; coreWriteData = 32'h0;
    mgmtValid = 1'b1; mgmtWrite = 1'b0; mgmtAddress = 12'h100; mgmtWriteData = 32'h0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("rr core_ready k%0d", k), {31'd0, coreReady},
               {31'd0, (k == 2 || k == 10)});
      check_eq($sformatf("rr mgmt_ready k%0d", k), {31'd0, mgmtReady},
               {31'd0, (k == 6 || k == 14)});
      if (k == 0 || k == 8)  check_eq("rr core_addr", {20'd0, csrAddress}, 32'h200);
      if (k == 4 || k == 12) check_eq("rr mgmt_addr", {20'd0, csrAddress}, 32'h100);
      if (k == 6) check_eq("rr mgmt_rdata", mgmtReadData, 32'h42);
      if (k == 14) begin
        @(negedge clk);
        coreValid = 1'b0; mgmtValid = 1'b0;
      end
    end
`else
    // Management port absent: a lone management request must be ignored.
    @(negedge clk);
    rd_val = 32'h42; claim_val = 1'b1;
    mgmtValid = 1'b1; mgmtWrite = 1'b1; mgmtAddress = 12'h340; mgmtWriteData = 32'h1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check_eq("nomgmt bus", {31'd0, csrReadEnable | csrWriteEnable}, 32'd0);
      check_eq("nomgmt ready", {31'd0, mgmtReady}, 32'd0);
    end
    mgmtValid = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
